obi_rvalid_stall: RTL and testbench

Response-phase perturbation stage for the CV32E40P example testbench, sitting directly downstream of the OBI grant-stall stage on the instruction or data port. It captures every read/write response the memory model returns, holds it in an in-order FIFO, and replays it to the core after a per-transaction delay. The delay is fixed, pseudo-random, or zero. It also reports when the outstanding-transaction budget is exhausted, so the upstream grant stage can withhold grants.

---
 rtl/obi_rvalid_stall.sv | 127 ++++++++++++
 tb/tb_obi_rvalid_stall.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rvalid_stall.sv
// OBI response-phase stall stage: buffers memory responses in order and replays
// each one to the core after a fixed, pseudo-random or zero per-transaction delay.
module obi_rvalid_stall #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] LFSR_SEED  = 32'hACE1_2021
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_i,
   input  logic                  gnt_i,
   input  logic                  rvalid_mem_i,
   input  logic [DATA_WIDTH-1:0] rdata_mem_i,
   output logic                  rvalid_core_o,
   output logic [DATA_WIDTH-1:0] rdata_core_o,
   output logic                  full_o,
   output logic                  err_o,
   input  logic                  en_stall_i,
   input  logic [31:0]           stall_mode_i,
   input  logic [31:0]           max_stall_i,
   input  logic [31:0]           valid_stall_i
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] IDX_ONE = AW'(1);

   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [7:0]            dly_q  [DEPTH];

   logic [AW:0]   wr_ptr_q, rd_ptr_q, fill;
   logic [AW:0]   out_cnt_q, out_cnt_d;
   logic [AW-1:0] rd_idx, nxt_idx, wr_idx;
   logic [7:0]    cnt_q, cnt_d, dly_new;
   logic [31:0]   lfsr_q, lfsr_nxt;
   logic [15:0]   rnd_mod;
   logic          full_q, err_q;
   logic          fifo_empty, fifo_full, no_outstanding;
   logic          accept, acc_ok, push, pop, err_set;
   logic          unused_bits;

   assign rd_idx     = rd_ptr_q[AW-1:0];
   assign wr_idx     = wr_ptr_q[AW-1:0];
   assign nxt_idx    = rd_idx + IDX_ONE;
   assign fill       = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

   // A response is only legal while some accepted request still awaits one.
   assign no_outstanding = (out_cnt_q == fill);
   assign accept         = req_i && gnt_i;
   assign acc_ok         = accept && !full_q;
   assign push           = rvalid_mem_i && !fifo_full && !no_outstanding;
   assign pop            = rvalid_core_o;
   assign err_set        = (rvalid_mem_i && (fifo_full || no_outstanding)) || (accept && full_q);

   assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
   assign rnd_mod  = lfsr_q[15:0] % ({8'd0, max_stall_i[7:0]} + 16'd1);

   assign unused_bits = ^{max_stall_i[31:8], valid_stall_i[31:8], rnd_mod[15:8]};

   always_comb begin
      dly_new = 8'd0;
      if (en_stall_i) begin
         case (stall_mode_i)
            32'd1:   dly_new = valid_stall_i[7:0];
            32'd2:   dly_new = rnd_mod[7:0];
            default: dly_new = 8'd0;
         endcase
      end
   end

   // The head counter reloads whenever a new entry reaches the head.
   always_comb begin
      cnt_d = cnt_q;
      if (pop) begin
         if (fill > CNT_ONE) cnt_d = dly_q[nxt_idx];
         else if (push)      cnt_d = dly_new;
         else                cnt_d = 8'd0;
      end else if (push && fifo_empty) begin
         cnt_d = dly_new;
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (acc_ok && !pop)      out_cnt_d = out_cnt_q + CNT_ONE;
      else if (!acc_ok && pop) out_cnt_d = out_cnt_q - CNT_ONE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= 8'd0;
         out_cnt_q <= '0;
         full_q    <= 1'b0;
         err_q     <= 1'b0;
         lfsr_q    <= LFSR_SEED;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + CNT_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + CNT_ONE;
         cnt_q     <= cnt_d;
         out_cnt_q <= out_cnt_d;
         full_q    <= (out_cnt_d == FULL_CNT);
         if (err_set) err_q  <= 1'b1;
         if (push)    lfsr_q <= lfsr_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         data_q[wr_idx] <= rdata_mem_i;
         dly_q[wr_idx]  <= dly_new;
      end
   end

   assign rvalid_core_o = !fifo_empty && (cnt_q == 8'd0);
   assign rdata_core_o  = rvalid_core_o ? data_q[rd_idx] : '0;
   assign full_o        = full_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_obi_rvalid_stall.sv
// Bench for obi_rvalid_stall: random core/memory traffic against a queue model that
// predicts each response's presentation cycle, plus directed literal scenarios.
module tb_obi_rvalid_stall;

   localparam int          DEPTH = 4;
   localparam int          DW    = 32;
   localparam logic [31:0] SEED  = 32'hACE1_2021;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b1;
   logic          req_i = 1'b0, gnt_i = 1'b0, rvalid_mem_i = 1'b0;
   logic [DW-1:0] rdata_mem_i = '0;
   logic          rvalid_core_o, full_o, err_o;
   logic [DW-1:0] rdata_core_o;
   logic          en_stall_i = 1'b0;
   logic [31:0]   stall_mode_i = '0, max_stall_i = '0, valid_stall_i = '0;

   always #5 clk_i = ~clk_i;

   obi_rvalid_stall #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .LFSR_SEED(SEED)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_i(gnt_i),
      .rvalid_mem_i(rvalid_mem_i), .rdata_mem_i(rdata_mem_i),
      .rvalid_core_o(rvalid_core_o), .rdata_core_o(rdata_core_o),
      .full_o(full_o), .err_o(err_o), .en_stall_i(en_stall_i),
      .stall_mode_i(stall_mode_i), .max_stall_i(max_stall_i), .valid_stall_i(valid_stall_i));

   typedef struct {
      logic [31:0] data;
      int          t;
      int          push_c;
   } ent_t;

   int          n_cmp = 0, n_bad = 0;
   ent_t        fq[$];
   logic [31:0] mem_q[$];
   int          obs_d[$];
   int          cyc = 0, last_t = -1, m_out = 0, dut_last_pop = -1, n_pops = 0;
   bit          m_err = 0, exp_full = 0, exp_err = 0, chk_en = 0, rec_en = 0;
   logic [31:0] m_lfsr = SEED;
   logic        cfg_en = 1'b0;
   logic [31:0] cfg_mode = '0, cfg_max = '0, cfg_vs = '0;

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'd0);
   endfunction

   function automatic int model_delay();
      int unsigned r, m;
      if (!cfg_en) return 0;
      case (cfg_mode)
         32'd1: return int'(cfg_vs[7:0]);
         32'd2: begin
            r = m_lfsr[15:0];
            m = cfg_max[7:0];
            return int'(r % (m + 1));
         end
         default: return 0;
      endcase
   endfunction

   // One clock cycle: drive inputs just after the edge and advance the model.
   task automatic tick(input bit rq, input bit rs, input bit frc, input logic [31:0] adat);
      bit          acc;
      logic [31:0] rd;
      int          d;
      ent_t        e;
      @(posedge clk_i); #1;
      cyc++;
      chk_en   = 1;
      exp_full = (m_out == DEPTH);
      exp_err  = m_err;
      acc      = rq && (frc || m_out != DEPTH);
      rd       = (rs && mem_q.size() > 0) ? mem_q[0] : $urandom;
      if (rs) begin
         if (fq.size() == DEPTH || m_out == fq.size()) m_err = 1;
         else begin
            d        = model_delay();
            e.data   = rd;
            e.t      = ((cyc > last_t) ? cyc : last_t) + 1 + d;
            e.push_c = cyc;
            fq.push_back(e);
            last_t = e.t;
            m_lfsr = lfsr_step(m_lfsr);
            void'(mem_q.pop_front());
         end
      end
      if (acc) begin
         if (m_out == DEPTH) m_err = 1;
         else begin
            m_out++;
            mem_q.push_back(adat);
         end
      end
      req_i = rq; gnt_i = acc; rvalid_mem_i = rs; rdata_mem_i = rd;
      en_stall_i = cfg_en; stall_mode_i = cfg_mode; max_stall_i = cfg_max; valid_stall_i = cfg_vs;
   endtask

   task automatic do_reset(input bit chk_now);
      chk_en = 0;
      rst_ni = 1'b0;
      req_i = 0; gnt_i = 0; rvalid_mem_i = 0; rdata_mem_i = '0;
      #1;
      if (chk_now) begin
         check1("rst_rvalid", rvalid_core_o, 1'b0);
         check32("rst_rdata", rdata_core_o, 32'd0);
         check1("rst_full", full_o, 1'b0);
         check1("rst_err", err_o, 1'b0);
      end
      fq.delete(); mem_q.delete();
      last_t = -1; m_out = 0; m_err = 0; m_lfsr = SEED; dut_last_pop = -1;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic run_rand(input int n_tx, input int max_cyc);
      int start, k;
      start = n_pops;
      k = 0;
      while (n_pops - start < n_tx && k < max_cyc) begin
         tick(1'($urandom_range(0, 1)), (mem_q.size() > 0) && ($urandom_range(0, 1) == 1), 0, $urandom);
         k++;
      end
      check1("rand_budget", (n_pops - start >= n_tx), 1'b1);
   endtask

   always @(negedge clk_i) begin : cmp_p
      bit          ev;
      logic [31:0] ed;
      int          base;
      if (chk_en) begin
         ev = (fq.size() > 0) && (fq[0].t == cyc);
         ed = ev ? fq[0].data : 32'd0;
         check1("rvalid", rvalid_core_o, ev);
         check32("rdata", rdata_core_o, ed);
         check1("full", full_o, exp_full);
         check1("err", err_o, exp_err);
         if (rvalid_core_o === 1'b1 && fq.size() > 0) begin
            base = (fq[0].push_c > dut_last_pop) ? fq[0].push_c : dut_last_pop;
            if (rec_en) obs_d.push_back(cyc - base - 1);
            dut_last_pop = cyc;
         end
         if (ev) begin
            void'(fq.pop_front());
            m_out--;
            n_pops++;
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int          run1[$];
      int          tp, p, n_out, n_dist, n_diff;
      bit          got;
      logic [12:0] seen;
      bit [255:0]  dseen;

      #1;
      do_reset(1);

      // OFF: back-to-back responses come straight through
      cfg_en = 0; cfg_mode = 0;
      tick(1, 0, 0, 32'h11); tick(1, 0, 0, 32'h22); tick(1, 0, 0, 32'h33);
      tick(0, 1, 0, 0);
      check1("off_v0", rvalid_core_o, 1'b0);
      tick(0, 1, 0, 0);
      check1("off_v1", rvalid_core_o, 1'b1); check32("off_d1", rdata_core_o, 32'h11);
      tick(0, 1, 0, 0);
      check1("off_v2", rvalid_core_o, 1'b1); check32("off_d2", rdata_core_o, 32'h22);
      tick(0, 0, 0, 0);
      check1("off_v3", rvalid_core_o, 1'b1); check32("off_d3", rdata_core_o, 32'h33);
      tick(0, 0, 0, 0);
      check1("off_v4", rvalid_core_o, 1'b0); check1("off_err", err_o, 1'b0);

      // STANDARD 3: pushes at T and T+1 show up at T+4 and T+8
      do_reset(0);
      cfg_en = 1; cfg_mode = 1; cfg_vs = 3;
      tick(1, 0, 0, 32'hB1); tick(1, 0, 0, 32'hB2);
      seen = '0;
      for (int k = 0; k <= 12; k++) begin
         tick(0, k < 2, 0, 0);
         seen[k] = rvalid_core_o;
      end
      check32("std3_pattern", {19'd0, seen}, 32'h110);

      // push into a one-entry FIFO on the cycle of its pop, new delay 0
      do_reset(0);
      cfg_en = 1; cfg_mode = 1; cfg_vs = 2;
      tick(1, 0, 0, 32'hA1); tick(1, 0, 0, 32'hA2);
      tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
      cfg_vs = 0;
      tick(0, 1, 0, 0);
      check1("pp_v1", rvalid_core_o, 1'b1); check32("pp_d1", rdata_core_o, 32'hA1);
      tick(0, 0, 0, 0);
      check1("pp_v2", rvalid_core_o, 1'b1); check32("pp_d2", rdata_core_o, 32'hA2);
      tick(0, 0, 0, 0);
      check1("pp_v3", rvalid_core_o, 1'b0);

      // full_o timing and a forced accept while full
      do_reset(0);
      cfg_en = 1; cfg_mode = 1; cfg_vs = 10;
      for (int k = 0; k < 4; k++) tick(1, 0, 0, 32'hC0 + k);
      check1("full_before", full_o, 1'b0);
      tick(1, 0, 1, 32'hCF);
      check1("full_set", full_o, 1'b1);
      tick(0, 0, 0, 0);
      check1("full_err", err_o, 1'b1);
      tick(0, 1, 0, 0);
      tp = cyc;
      for (int k = 0; k < 3; k++) tick(0, 1, 0, 0);
      got = 0; p = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick(0, 0, 0, 0);
         if (rvalid_core_o === 1'b1) begin got = 1; p = cyc; end
      end
      check1("full_pop_seen", got, 1'b1);
      check32("full_pop_lat", p - tp, 32'd11);
      tick(0, 0, 0, 0);
      check1("full_clear", full_o, 1'b0);

      // response with no outstanding accept
      do_reset(0);
      cfg_en = 0; cfg_mode = 0;
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
      check1("spur_err", err_o, 1'b1); check1("spur_v", rvalid_core_o, 1'b0);
      for (int k = 0; k < 4; k++) tick(0, 0, 0, 0);

      // RANDOM with max 0 behaves like OFF
      do_reset(0);
      cfg_en = 1; cfg_mode = 2; cfg_max = 0;
      tick(1, 0, 0, 32'h55);
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
      check1("rnd0_v", rvalid_core_o, 1'b1); check32("rnd0_d", rdata_core_o, 32'h55);
      run_rand(30, 1000);

      // RANDOM max 7: two runs from reset must give the same delays
      cfg_max = 7;
      do_reset(0);
      obs_d.delete(); rec_en = 1;
      run_rand(200, 5000);
      run1 = obs_d;
      do_reset(0);
      obs_d.delete();
      run_rand(200, 5000);
      rec_en = 0;
      check32("rnd_len1", run1.size(), 32'd200);
      check32("rnd_len2", obs_d.size(), run1.size());
      n_diff = 0; n_out = 0; n_dist = 0; dseen = '0;
      for (int i = 0; i < run1.size(); i++) begin
         if (i >= obs_d.size() || obs_d[i] != run1[i]) n_diff++;
         if (run1[i] < 0 || run1[i] > 7) n_out++;
         else dseen[run1[i]] = 1'b1;
      end
      for (int i = 0; i < 8; i++) if (dseen[i]) n_dist++;
      check32("rnd_repeat", n_diff, 32'd0);
      check32("rnd_range", n_out, 32'd0);
      check1("rnd_distinct", n_dist >= 4, 1'b1);
      check32("rnd_d0", (run1.size() > 1) ? run1[0] : -1, 32'd1);
      check32("rnd_d1", (run1.size() > 1) ? run1[1] : -1, 32'd3);

      // mixed modes, then a reset in the middle of traffic
      do_reset(0);
      for (int s = 0; s < 6; s++) begin
         cfg_en = 1'($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: cfg_mode = 0;
            1: cfg_mode = 1;
            2: cfg_mode = 2;
            default: cfg_mode = 5;
         endcase
         cfg_vs  = $urandom_range(0, 5);
         cfg_max = $urandom_range(0, 9);
         run_rand(25, 1500);
      end
      tick(1, 0, 0, 32'hD0);
      tick(0, 1, 0, 0);
      do_reset(1);
      cfg_en = 0; cfg_mode = 0;
      run_rand(10, 400);

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
